pipe_hazard_ctrl: RTL and testbench

//  Central hazard/stall controller for the 5-stage RISC-V pipeline. Drives stall (enable-low) and

---
 rtl/pipe_hazard_ctrl_if.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory request handshake between the hazard controller and the M-stage memory port.
//   dmem_reqM  : instruction in M performs a memory access
//   dmem_ready : memory completes the access this cycle
//   dmem_valid : request strobe to memory
//   bus_error  : sticky access-timeout flag
// The controller uses the master modport; the pipeline/memory side uses slave.
interface pipe_hazard_ctrl_if;
  logic dmem_reqM;
  logic dmem_ready;
  logic dmem_valid;
  logic bus_error;

  modport master (
    input  dmem_reqM,
    input  dmem_ready,
    output dmem_valid,
    output bus_error
  );

  modport slave (
    output dmem_reqM,
    output dmem_ready,
    input  dmem_valid,
    input  bus_error
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/stall controller for a 5-stage RISC-V pipeline.
// Generates stall/flush controls for the F/D/E/M/W registers, EX-stage forwarding selects,
// and runs the data-memory wait-state FSM with access timeout and a stall-cycle counter.
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   rs1D, rs2D, rs1E, rs2E          source registers of the instructions in D and E
//   rdE, rdM, rdW                   destination registers in E/M/W
//   regwriteM, regwriteW            M/W instruction writes rd
//   loadE, pcsrcE                   E holds a load / taken branch resolved in E
//   perf_clr                        synchronous clear of stall_cycles
//   stallF/D/E/M, flushD/E/W        pipeline register hold / clear-to-bubble
//   forwardAE, forwardBE            00 regfile, 10 from M, 01 from W
//   stall_cycles                    saturating count of cycles with stallF=1
//   mem                             memory handshake (dmem_reqM/ready/valid, bus_error)
module pipe_hazard_ctrl #(
  parameter int unsigned REGW        = 5,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNTW        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REGW-1:0]     rs1D,
  input  logic [REGW-1:0]     rs2D,
  input  logic [REGW-1:0]     rs1E,
  input  logic [REGW-1:0]     rs2E,
  input  logic [REGW-1:0]     rdE,
  input  logic [REGW-1:0]     rdM,
  input  logic [REGW-1:0]     rdW,
  input  logic                regwriteM,
  input  logic                regwriteW,
  input  logic                loadE,
  input  logic                pcsrcE,
  input  logic                perf_clr,
  output logic                stallF,
  output logic                stallD,
  output logic                stallE,
  output logic                stallM,
  output logic                flushD,
  output logic                flushE,
  output logic                flushW,
  output logic [1:0]          forwardAE,
  output logic [1:0]          forwardBE,
  output logic [CNTW-1:0]     stall_cycles,
  pipe_hazard_ctrl_if.master  mem
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t          state;
  logic [CNTW-1:0] wait_cnt;
  logic            bus_error_q;
  logic            mem_stall;
  logic            dmem_valid_c;
  logic            lw_stall;

  assign mem.dmem_valid = dmem_valid_c;
  assign mem.bus_error  = bus_error_q;

  // EX-stage forwarding: the younger result in M takes priority over W.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (regwriteM && (rdM != '0) && (rdM == rs1E))      forwardAE = 2'b10;
    else if (regwriteW && (rdW != '0) && (rdW == rs1E)) forwardAE = 2'b01;
    if (regwriteM && (rdM != '0) && (rdM == rs2E))      forwardBE = 2'b10;
    else if (regwriteW && (rdW != '0) && (rdW == rs2E)) forwardBE = 2'b01;
  end

  assign lw_stall = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  // Memory handshake decode; the strobe is only issued on the first cycle of an access.
  always_comb begin
    mem_stall    = 1'b0;
    dmem_valid_c = 1'b0;
    unique case (state)
      S_RUN: begin
        dmem_valid_c = mem.dmem_reqM;
        mem_stall    = mem.dmem_reqM && !mem.dmem_ready;
      end
      S_WAIT:  mem_stall = !mem.dmem_ready;
      S_ERR:   mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Stall/flush generation; a memory stall freezes everything and suppresses the
  // load-use and branch hazards until the pipeline moves again.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (mem_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else begin
      // A taken branch discards the stalled load consumer, so it overrides the hold.
      stallF = lw_stall && !pcsrcE;
      stallD = lw_stall && !pcsrcE;
      flushE = lw_stall || pcsrcE;
      flushD = pcsrcE;
    end
  end

  // Wait-state FSM, sticky timeout flag and stall performance counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_RUN;
      wait_cnt     <= '0;
      bus_error_q  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      unique case (state)
        S_RUN: begin
          if (mem.dmem_reqM && !mem.dmem_ready) begin
            state    <= S_WAIT;
            wait_cnt <= CNTW'(1);
          end
        end
        S_WAIT: begin
          if (mem.dmem_ready) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNTW'(MEM_TIMEOUT)) begin
            state       <= S_ERR;
            bus_error_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNTW'(1);
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_RUN;
      endcase

      if (perf_clr)                            stall_cycles <= '0;
      else if (stallF && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// expectations from a transaction-level model of the hazard and memory-access rules.
module tb_pipe_hazard_ctrl;
  localparam int unsigned REGW        = 5;
  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNTW        = 6;
  localparam int          CNT_MAX     = (1 << CNTW) - 1;

  typedef struct packed {
    logic            rst;
    logic [REGW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic            regwriteM, regwriteW, loadE, pcsrcE, reqM, ready, perf_clr;
  } stim_t;

  typedef struct packed {
    logic            stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [1:0]      fa, fb;
    logic            dmem_valid, bus_error;
    logic [CNTW-1:0] stall_cycles;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  logic [REGW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic regwriteM, regwriteW, loadE, pcsrcE, perf_clr;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0] forwardAE, forwardBE;
  logic [CNTW-1:0] stall_cycles;

  pipe_hazard_ctrl_if mif ();

  pipe_hazard_ctrl #(.REGW(REGW), .MEM_TIMEOUT(MEM_TIMEOUT), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regwriteM(regwriteM), .regwriteW(regwriteW), .loadE(loadE), .pcsrcE(pcsrcE),
    .perf_clr(perf_clr),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stall_cycles(stall_cycles),
    .mem(mif)
  );

  always #5 clk = ~clk;

  // Scoreboard
  obs_t  exp_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  // Reference model: an access is either idle, outstanding for a number of stalled
  // cycles, or has timed out (sticky until reset).
  bit m_err;
  int m_pending;
  int m_stalls;

  function automatic logic [1:0] fwd(input stim_t s, input logic [REGW-1:0] rs);
    if (s.regwriteM && s.rdM != 0 && s.rdM == rs) return 2'b10;
    if (s.regwriteW && s.rdW != 0 && s.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic obs_t predict(input stim_t s);
    obs_t e;
    bit   lw, mstall;
    e  = '0;
    lw = s.loadE && s.rdE != 0 && (s.rdE == s.rs1D || s.rdE == s.rs2D);
    if (m_err) begin
      mstall = 1;
    end else if (m_pending > 0) begin
      mstall = !s.ready;
    end else begin
      e.dmem_valid = s.reqM;
      mstall       = s.reqM && !s.ready;
    end
    if (mstall) begin
      {e.stallF, e.stallD, e.stallE, e.stallM, e.flushW} = 5'b11111;
    end else begin
      e.stallF = lw && !s.pcsrcE;
      e.stallD = lw && !s.pcsrcE;
      e.flushE = lw || s.pcsrcE;
      e.flushD = s.pcsrcE;
    end
    e.fa           = fwd(s, s.rs1E);
    e.fb           = fwd(s, s.rs2E);
    e.bus_error    = m_err;
    e.stall_cycles = CNTW'(m_stalls);
    return e;
  endfunction

  task automatic model_reset();
    m_err     = 0;
    m_pending = 0;
    m_stalls  = 0;
  endtask

  task automatic model_edge(input stim_t s, input obs_t e);
    if (s.rst) begin
      model_reset();
      return;
    end
    if (!m_err) begin
      if (m_pending > 0) begin
        if (s.ready) m_pending = 0;
        else begin
          m_pending++;
          if (m_pending > MEM_TIMEOUT) m_err = 1;
        end
      end else if (s.reqM && !s.ready) begin
        m_pending = 1;
      end
    end
    if (s.perf_clr) m_stalls = 0;
    else if (e.stallF && m_stalls < CNT_MAX) m_stalls++;
  endtask

  // Apply one cycle of stimulus and queue its expected response.
  task automatic apply(input stim_t s, input string tag);
    obs_t e;
    @(negedge clk);
    reset          = s.rst;
    rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
    rdE  = s.rdE;  rdM  = s.rdM;  rdW  = s.rdW;
    regwriteM      = s.regwriteM;
    regwriteW      = s.regwriteW;
    loadE          = s.loadE;
    pcsrcE         = s.pcsrcE;
    perf_clr       = s.perf_clr;
    mif.dmem_reqM  = s.reqM;
    mif.dmem_ready = s.ready;
    if (s.rst) model_reset();
    e = predict(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    model_edge(s, e);
  endtask

  // Monitor: compare the DUT outputs mid-cycle against the oldest expectation.
  initial begin
    obs_t  a, e;
    string t;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, forwardAE, forwardBE,
             mif.dmem_valid, mif.bus_error, stall_cycles};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s at %0t: got %b (stall_cycles=%0d) expected %b (stall_cycles=%0d)",
                   t, $time, a, a.stall_cycles, e, e.stall_cycles);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    budget;

    reset = 1'b1;
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {regwriteM, regwriteW, loadE, pcsrcE, perf_clr} = '0;
    mif.dmem_reqM  = 1'b0;
    mif.dmem_ready = 1'b0;
    model_reset();

    s = '0; s.rst = 1;
    apply(s, "reset_zero");
    apply(s, "reset_zero");

    // Forwarding priority
    s = '0; s.rdM = 5; s.regwriteM = 1; s.rdW = 5; s.regwriteW = 1; s.rs1E = 5; s.rs2E = 5;
    apply(s, "fwd_m_beats_w");
    s.rdM = 0;
    apply(s, "fwd_w_when_rdm_zero");
    s.rs2E = 0;
    apply(s, "fwd_x0_regfile");

    // Load-use stall, then the counter reflects it
    s = '0; s.loadE = 1; s.rdE = 3; s.rs2D = 3;
    apply(s, "load_use_stall");
    s = '0;
    apply(s, "stall_count_after_lw");

    // Branch overrides load-use stall
    s = '0; s.loadE = 1; s.rdE = 3; s.rs1D = 3; s.pcsrcE = 1;
    apply(s, "branch_beats_lw");

    // Zero-wait access
    s = '0; s.perf_clr = 1;
    apply(s, "perf_clr");
    s = '0; s.reqM = 1; s.ready = 1;
    apply(s, "zero_wait_access");
    s = '0;
    apply(s, "after_zero_wait");

    // Three wait cycles then ready
    s = '0; s.reqM = 1;
    for (int i = 0; i < 3; i++) apply(s, "wait_state");
    s.ready = 1;
    apply(s, "wait_ready");
    s = '0;
    apply(s, "wait_count3");

    // Reset in the middle of a wait
    s = '0; s.reqM = 1;
    apply(s, "wait_before_reset");
    apply(s, "wait_before_reset");
    s = '0; s.rst = 1;
    apply(s, "reset_mid_wait");
    s = '0;
    apply(s, "run_after_reset");

    // Timeout, sticky error, counter saturation, recovery by reset
    s = '0; s.reqM = 1;
    for (int i = 0; i < 8; i++) apply(s, "timeout");
    s.ready = 1; s.loadE = 1; s.rdE = 2; s.rs1D = 2; s.pcsrcE = 1;
    for (int i = 0; i < 60; i++) apply(s, "err_sticky_saturate");
    s = '0; s.rst = 1;
    apply(s, "reset_from_err");
    s = '0;
    apply(s, "run_after_err_reset");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      s = '0;
      s.rst       = ($urandom_range(0, 99) == 0);
      s.rs1D      = REGW'($urandom_range(0, 3));
      s.rs2D      = REGW'($urandom_range(0, 3));
      s.rs1E      = REGW'($urandom_range(0, 3));
      s.rs2E      = REGW'($urandom_range(0, 3));
      s.rdE       = REGW'($urandom_range(0, 3));
      s.rdM       = REGW'($urandom_range(0, 3));
      s.rdW       = REGW'($urandom_range(0, 3));
      s.regwriteM = 1'($urandom_range(0, 1));
      s.regwriteW = 1'($urandom_range(0, 1));
      s.loadE     = ($urandom_range(0, 9) < 4);
      s.pcsrcE    = ($urandom_range(0, 9) < 2);
      s.perf_clr  = ($urandom_range(0, 99) < 3);
      s.reqM      = (m_pending > 0) || ($urandom_range(0, 9) < 3);
      s.ready     = ($urandom_range(0, 9) < 4);
      apply(s, "random");
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #5;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
